audio_line_packer: RTL and testbench
====================================

# audio_line_packer

Packs a stream of 32-bit audio samples into 512-bit lines and writes them, one line per write strobe, into the 4096-line audio line sink at consecutive indices 0..4095. Sits upstream of the line-capture memory: it is the line-writing transmitter that drives the sink's write enable, index and data inputs. The audio datapath uses it to turn per-sample processing output back into the line-addressed storage format.

## Interface
- SAMPLE_W, 32, bits per sample
- LINE_W, 512, bits per line; must be a multiple of SAMPLE_W
- DEPTH, 4096, lines in the sink; must be a power of two
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  single-cycle pulse; begins a capture at line 0
- in_valid  in  1  sample present on in_data
- in_data  in  SAMPLE_W  sample
- in_ready  out  1  packer accepts a sample this cycle
- flush  in  1  write the partial line now (see Configuration)
- wr_en  out  1  one-cycle line write strobe to the sink
- wr_index  out  $clog2(DEPTH)  line index for wr_en
- wr_data  out  LINE_W  line contents for wr_en
- busy  out  1  capture in progress (FILL or WRITE)
- done  out  1  all DEPTH lines written; held until start or reset

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE/DONE + start -> FILL; line index = 0, slot = 0, line buffer = 0, done = 0.
- start in FILL or WRITE is ignored.
- FILL: in_ready = 1. A handshake (in_valid & in_ready) stores in_data at bits [slot*SAMPLE_W +: SAMPLE_W]; sample 0 of a line sits at the LSBs. slot increments.
- The handshake that fills the last slot (LINE_W/SAMPLE_W - 1 = 15) -> WRITE.
- WRITE: in_ready = 0; wr_en = 1 for exactly this cycle; wr_index = current line index; wr_data = line buffer.
- Leaving WRITE: buffer cleared to 0 and slot = 0. Line index == DEPTH-1 -> DONE. Otherwise the index increments -> FILL. The index never wraps within a capture.
- DONE: in_ready = 0, done = 1, wr_en = 0.
- Arithmetic: slot is $clog2(LINE_W/SAMPLE_W) bits. The index is $clog2(DEPTH) bits and unsigned.

## Timing
- Reset values: in_ready 0, wr_en 0, wr_index 0, wr_data 0, busy 0, done 0; state IDLE.
- Reset mid-capture returns to IDLE. A partial line is discarded and no write is issued.
- in_ready is 1 on the cycle after start.
- wr_en rises the cycle after the 16th handshake of a line. wr_data and wr_index are registered and stable while wr_en = 1.
- Throughput: 16 samples per 17 cycles at full in_valid. A full capture takes 4096 × 17 cycles after start.
- done rises the cycle after the final wr_en.
- Outside wr_en, wr_data and wr_index are don't-care to the sink but remain deterministic (buffer contents and current index).

## Configuration
- AUDIO_PACK_FLUSH_EN defined:
  - flush in FILL with slot > 0 -> WRITE next cycle; unfilled slots are zero.
  - flush with slot == 0 is ignored.
  - flush with a handshake in the same cycle: the sample is stored first, then the line is written.
  - If that sample is the 16th, it is a single normal write.
- AUDIO_PACK_FLUSH_EN undefined: the flush port remains, for a stable instance footprint, but it is ignored. Only full lines are written.

## Structure
- Shared package audio_pkg:
  - SAMPLE_W, LINE_W and DEPTH defaults
  - derived SAMPLES_PER_LINE, INDEX_W and SLOT_W
  - packer state enum (IDLE, FILL, WRITE, DONE)
- Single module. No sub-module: the state register, slot counter, index counter and line buffer are small enough to keep flat.

## Test plan
- Reset, then start; feed samples i = 0..15 with values 32'h1000+i, in_valid constant -> one wr_en at index 0; wr_data[31:0] = 32'h1000 and wr_data[511:480] = 32'h100F. wr_en rises exactly one cycle after the 16th handshake.
- Full capture with sample value = global count 0..65535 -> exactly 4096 wr_en pulses at indices 0..4095 in order; done = 1 one cycle after the last; in_ready = 0 thereafter. The sink's line 4095 bits [511:480] = 65535.
- Random in_valid gaps (≈50 % duty) -> line contents are identical to the gap-free run; no sample is lost or duplicated; in_ready = 0 in every WRITE cycle.
- Assert rst_n = 0 after 7 samples of line 3 -> no wr_en; all outputs return to reset values next cycle. A new start writes line 0 first.
- start pulse during FILL of line 2 -> ignored; index progression continues at 2, 3.
- With AUDIO_PACK_FLUSH_EN: 5 samples then flush -> wr_en at the current index, wr_data[159:0] holds the samples, wr_data[511:160] = 0. Then flush with slot 0 -> no write; flush together with the 16th handshake -> a single write.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared sizing and state encoding for the audio line packer.
// Samples are packed LSB-first into lines; the sink holds DEPTH lines.
package audio_pkg;

    localparam int SAMPLE_W         = 32;
    localparam int LINE_W           = 512;
    localparam int DEPTH            = 4096;

    localparam int SAMPLES_PER_LINE = LINE_W / SAMPLE_W;
    localparam int INDEX_W          = $clog2(DEPTH);
    localparam int SLOT_W           = $clog2(SAMPLES_PER_LINE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_e;

endpackage

// File: rtl/audio_line_packer.sv
// audio_line_packer: gathers SAMPLE_W-bit samples into LINE_W-bit lines and
// writes each completed line to the sink at indices 0..DEPTH-1, one strobe
// per line. Optional early write of a partial line is enabled by defining
// AUDIO_PACK_FLUSH_EN; without it the flush port is present but ignored.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1; in_ready depends only on the packer state, never on
// in_valid, and the source must hold in_data stable while in_valid waits.
module audio_line_packer
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic                flush,
    output logic                wr_en,
    output logic [INDEX_W-1:0]  wr_index,
    output logic [LINE_W-1:0]   wr_data,
    output logic                busy,
    output logic                done
);

    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SAMPLES_PER_LINE - 1);
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DEPTH - 1);

    pack_state_e         state_q, state_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [LINE_W-1:0]   buf_q,   buf_d;
    logic                hs;

`ifndef AUDIO_PACK_FLUSH_EN
    // flush is kept on the port list so the instance looks the same in both builds
    logic unused_flush;
    assign unused_flush = flush;
`endif

    assign in_ready = (state_q == ST_FILL);
    assign hs       = in_valid & in_ready;

    // Outputs come straight from registers so the sink sees stable values
    assign wr_en    = (state_q == ST_WRITE);
    assign wr_index = index_q;
    assign wr_data  = buf_q;
    assign busy     = (state_q == ST_FILL) || (state_q == ST_WRITE);
    assign done     = (state_q == ST_DONE);

    // Next-state, slot, index and line-buffer update
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        index_d = index_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FILL;
                    slot_d  = '0;
                    index_d = '0;
                    buf_d   = '0;
                end
            end
            ST_FILL: begin
                // start is deliberately ignored while a capture runs
                if (hs) begin
                    buf_d[slot_q*SAMPLE_W +: SAMPLE_W] = in_data;
                    slot_d = slot_q + 1'b1;
                end
                if (hs && (slot_q == LAST_SLOT)) begin
                    state_d = ST_WRITE;
                end
`ifdef AUDIO_PACK_FLUSH_EN
                // An accepted sample in the flush cycle counts toward the line
                else if (flush && (hs || (slot_q != '0))) begin
                    state_d = ST_WRITE;
                end
`endif
            end
            ST_WRITE: begin
                buf_d  = '0;
                slot_d = '0;
                if (index_q == LAST_INDEX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            index_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            index_q <= index_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_audio_line_packer.sv
// tb_audio_line_packer: scenario tasks driven from one initial block; a
// negedge monitor compares every write strobe against lines predicted by a
// sample-list model (samples grouped SAMPLES_PER_LINE at a time, LSB first).
module tb_audio_line_packer;
    import audio_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_ready;
    logic                flush;
    logic                wr_en;
    logic [INDEX_W-1:0]  wr_index;
    logic [LINE_W-1:0]   wr_data;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    // Reference model state
    logic [SAMPLE_W-1:0] cur_q[$];
    logic [LINE_W-1:0]   exp_q[$];
    int                  exp_idx_q[$];
    int                  line_idx = 0;

    audio_line_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: lines are the sample list cut into groups, first sample at LSBs
    function automatic logic [LINE_W-1:0] pack_line(input logic [SAMPLE_W-1:0] s[$]);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int j = 0; j < s.size(); j++) l[j*SAMPLE_W +: SAMPLE_W] = s[j];
        return l;
    endfunction

    task automatic model_sample(input logic [SAMPLE_W-1:0] v);
        cur_q.push_back(v);
        if (cur_q.size() == SAMPLES_PER_LINE) begin
            exp_q.push_back(pack_line(cur_q));
            exp_idx_q.push_back(line_idx);
            line_idx++;
            cur_q.delete();
        end
    endtask

    task automatic model_flush();
        if (cur_q.size() > 0) begin
            exp_q.push_back(pack_line(cur_q));
            exp_idx_q.push_back(line_idx);
            line_idx++;
            cur_q.delete();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logic [LINE_W-1:0] el;
            int                ei;
            wr_count++;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_in_write: got %b want 0", in_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: index %0d, no line expected", wr_index);
            end else begin
                el = exp_q.pop_front();
                ei = exp_idx_q.pop_front();
                if (wr_index !== INDEX_W'(ei) || wr_data !== el) begin
                    errors++;
                    $display("FAIL line_write: got index %0d data %h want index %0d data %h",
                             wr_index, wr_data[127:0], ei, el[127:0]);
                end
            end
        end
    end

    // Drivers
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; flush = 1'b0;
        cur_q.delete();
        line_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cur_q.delete();
        line_idx = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [SAMPLE_W-1:0] v, input bit gaps, input bit fl);
        int budget;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        flush    = fl;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready %b want 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            flush = 1'b0;
            return;
        end
        model_sample(v);
`ifdef AUDIO_PACK_FLUSH_EN
        if (fl) model_flush();
`endif
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d lines never written, want 0", name, exp_q.size());
        end
        exp_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || wr_index !== '0 || wr_data !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy %b wr %b idx %0d data0 %h busy %b done %b want all 0",
                     name, in_ready, wr_en, wr_index, wr_data[31:0], busy, done);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_first_line();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_start: got %b want 0", in_ready);
        end
        do_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_start: got rdy %b busy %b want 1 1", in_ready, busy);
        end
        for (int i = 0; i < SAMPLES_PER_LINE; i++) begin
            if (i == SAMPLES_PER_LINE - 1) begin
                checks++;
                if (wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL early_write: wr_en %b before 16th sample, want 0", wr_en);
                end
            end
            send(SAMPLE_W'(32'h1000 + i), 1'b0, 1'b0);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_index !== '0 || wr_data[31:0] !== 32'h1000 ||
            wr_data[511:480] !== 32'h100F) begin
            errors++;
            $display("FAIL first_line: got wr %b idx %0d lo %h hi %h want 1 0 00001000 0000100f",
                     wr_en, wr_index, wr_data[31:0], wr_data[511:480]);
        end
        check_drained("first_line");
    endtask

    task automatic test_random_gaps();
        do_reset();
        do_start();
        for (int g = 0; g < 4 * SAMPLES_PER_LINE; g++) send(SAMPLE_W'(g), 1'b1, 1'b0);
        check_drained("random_gaps");
        do_reset();
        do_start();
        for (int g = 0; g < 3 * SAMPLES_PER_LINE; g++) send($urandom, 1'b1, 1'b0);
        check_drained("random_data");
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        for (int g = 0; g < 3 * SAMPLES_PER_LINE + 7; g++) send(SAMPLE_W'(g), 1'b0, 1'b0);
        rst_n = 1'b0;
        cur_q.delete();
        line_idx = 0;
        @(negedge clk);
        check_reset_outputs("reset_mid_capture");
        rst_n = 1'b1;
        @(negedge clk);
        check_drained("reset_mid");
        do_start();
        for (int g = 0; g < SAMPLES_PER_LINE; g++) send($urandom, 1'b0, 1'b0);
        check_drained("restart_line0");
    endtask

    task automatic test_start_ignored();
        do_reset();
        do_start();
        for (int g = 0; g < 2 * SAMPLES_PER_LINE + 3; g++) send(SAMPLE_W'(g), 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_fill: got busy %b rdy %b want 1 1", busy, in_ready);
        end
        for (int g = 0; g < 2 * SAMPLES_PER_LINE - 3; g++) send($urandom, 1'b0, 1'b0);
        check_drained("start_ignored");
    endtask

    task automatic test_flush();
        int rest;
        do_reset();
        do_start();
        for (int g = 0; g < 5; g++) send(SAMPLE_W'(32'hA0 + g), 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef AUDIO_PACK_FLUSH_EN
        model_flush();
        checks++;
        if (wr_en !== 1'b1 || wr_data[511:160] !== '0 || wr_data[31:0] !== 32'hA0 ||
            wr_data[159:128] !== 32'hA4) begin
            errors++;
            $display("FAIL flush_partial: got wr %b lo %h s4 %h want 1 000000a0 000000a4, upper 0",
                     wr_en, wr_data[31:0], wr_data[159:128]);
        end
        @(negedge clk);
        rest = SAMPLES_PER_LINE;
`else
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_disabled: got wr %b want 0", wr_en);
        end
        rest = SAMPLES_PER_LINE - 5;
`endif
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_slot0_or_disabled: got wr %b want 0", wr_en);
        end
        for (int g = 0; g < rest; g++) send($urandom, 1'b0, (g == rest - 1));
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_16th_single: got wr %b want 0", wr_en);
        end
        check_drained("flush");
    endtask

    task automatic test_full_capture();
        do_reset();
        do_start();
        wr_count = 0;
        for (int g = 0; g < DEPTH * SAMPLES_PER_LINE; g++) send(SAMPLE_W'(g), 1'b0, 1'b0);
        checks++;
        if (wr_en !== 1'b1 || wr_index !== INDEX_W'(DEPTH - 1) || wr_data[511:480] !== 32'd65535) begin
            errors++;
            $display("FAIL last_line: got wr %b idx %0d hi %0d want 1 4095 65535",
                     wr_en, wr_index, wr_data[511:480]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL done_state: got done %b rdy %b busy %b wr %b want 1 0 0 0",
                     done, in_ready, busy, wr_en);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_held: got done %b rdy %b want 1 0", done, in_ready);
        end
        checks++;
        if (wr_count != DEPTH) begin
            errors++;
            $display("FAIL write_count: got %0d want %0d", wr_count, DEPTH);
        end
        check_drained("full_capture");
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_random_gaps();
        test_reset_mid();
        test_start_ignored();
        test_flush();
        test_full_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
